// File: rtl/addr_gen_pkg.sv
// Shared address-generator constants: command codes, FSM states, vector codes.
package addr_gen_pkg;

   typedef enum logic [2:0] {
      AB_PC   = 3'd0,
      AB_ZP   = 3'd1,
      AB_ABS  = 3'd2,
      AB_STK  = 3'd3,
      AB_NXT  = 3'd4,
      AB_VEC  = 3'd5,
      AB_JMP  = 3'd6,
      AB_HOLD = 3'd7
   } ab_op_e;

   typedef enum logic {
      ST_NORM = 1'b0,
      ST_FIX  = 1'b1
   } state_e;

   localparam logic [1:0] VEC_NMI = 2'b01;
   localparam logic [1:0] VEC_RST = 2'b10;
   localparam logic [1:0] VEC_IRQ = 2'b11;

   localparam logic [15:0] AB_RESET = 16'hFFFC;

   // Low byte of the vector address; code 00 is treated as IRQ/BRK.
   function automatic logic [7:0] vec_lo(input logic [1:0] v);
      logic [1:0] sel;
      sel = (v == 2'b00) ? VEC_IRQ : v;
      return {5'b11111, sel, 1'b0};
   endfunction

endpackage

// File: rtl/addr_gen_add8.sv
// 8-bit adder with carry-in and carry-out for the low-byte index add.
module add8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       ci_i,
   output logic [7:0] s_o,
   output logic       co_o
);

   logic [8:0] sum;

   always_comb begin
      sum  = {1'b0, a_i} + {1'b0, b_i} + {8'd0, ci_i};
      s_o  = sum[7:0];
      co_o = sum[8];
   end

endmodule

// File: rtl/addr_gen.sv
// Registered 16-bit address bus generator with PC, LO base and page-fix state.
module addr_gen
   import addr_gen_pkg::*;
(
   input  logic        clk,
   input  logic        RST,
   input  logic        RDY,
   input  logic [2:0]  ab_op,
   input  logic        pc_inc,
   input  logic        ld_lo,
   input  logic        wr,
   input  logic [1:0]  vec,
   input  logic [7:0]  SB,
   input  logic [7:0]  DB,
   output logic [15:0] AB,
   output logic [15:0] PC,
   output logic        fix
);

   state_e      state_q, state_d;
   logic [15:0] ab_q, ab_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  lo_q, lo_d;
   logic        carry_q, carry_d;

   logic [7:0]  add_a, add_s;
   logic        add_co;
   ab_op_e      op;

   assign op    = ab_op_e'(ab_op);
   // Zero page indexes off the fresh DB byte; absolute indexes off the latched LO.
   assign add_a = (op == AB_ZP) ? DB : lo_q;

   add8 u_add8 (
      .a_i  (add_a),
      .b_i  (SB),
      .ci_i (1'b0),
      .s_o  (add_s),
      .co_o (add_co)
   );

   always_comb begin
      state_d = state_q;
      ab_d    = ab_q;
      pc_d    = pc_q;
      lo_d    = lo_q;
      carry_d = carry_q;
      if (RDY) begin
         if (state_q == ST_FIX) begin
            ab_d    = {ab_q[15:8] + {7'd0, carry_q}, ab_q[7:0]};
            carry_d = 1'b0;
            state_d = ST_NORM;
         end else begin
            if (ld_lo) lo_d = DB;
            case (op)
               AB_PC: begin
                  ab_d = pc_q;
                  pc_d = pc_q + {15'd0, pc_inc};
               end
               AB_ZP:  ab_d = {8'h00, add_s};
               AB_ABS: begin
                  ab_d    = {DB, add_s};
                  carry_d = add_co;
                  if (add_co || wr) state_d = ST_FIX;
               end
               AB_STK: ab_d = {8'h01, SB};
               AB_NXT: ab_d = {ab_q[15:8], ab_q[7:0] + 8'd1};
               AB_VEC: ab_d = {8'hFF, vec_lo(vec)};
               AB_JMP: begin
                  ab_d = {DB, lo_q};
                  pc_d = {DB, lo_q} + {15'd0, pc_inc};
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q <= ST_NORM;
         ab_q    <= AB_RESET;
         pc_q    <= '0;
         lo_q    <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ab_q    <= ab_d;
         pc_q    <= pc_d;
         lo_q    <= lo_d;
         carry_q <= carry_d;
      end
   end

   assign AB  = ab_q;
   assign PC  = pc_q;
   assign fix = (state_q == ST_FIX);

endmodule

// File: tb/tb_addr_gen.sv
// Directed bench for addr_gen: expected bus/PC/fix values queued per step and checked after the edge.
module tb_addr_gen;
   import addr_gen_pkg::*;

   logic        clk = 1'b0;
   logic        RST = 1'b0;
   logic        RDY = 1'b1;
   logic [2:0]  ab_op = 3'd7;
   logic        pc_inc = 1'b0;
   logic        ld_lo = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  vec = 2'b00;
   logic [7:0]  SB = '0;
   logic [7:0]  DB = '0;
   logic [15:0] AB, PC;
   logic        fix;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [32:0] sb_q[$];

   addr_gen dut (
      .clk(clk), .RST(RST), .RDY(RDY), .ab_op(ab_op), .pc_inc(pc_inc),
      .ld_lo(ld_lo), .wr(wr), .vec(vec), .SB(SB), .DB(DB),
      .AB(AB), .PC(PC), .fix(fix)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_now(input string tag, input logic [32:0] e);
      chk({tag, ".AB"},  AB,  e[32:17]);
      chk({tag, ".PC"},  PC,  e[16:1]);
      chk({tag, ".fix"}, {15'd0, fix}, {15'd0, e[0]});
   endtask

   task automatic step(input string tag, input ab_op_e op, input logic inc, input logic ld,
                       input logic w, input logic [1:0] v, input logic [7:0] sbv,
                       input logic [7:0] dbv, input logic rdy,
                       input logic [15:0] eab, input logic [15:0] epc, input logic efix);
      logic [32:0] e;
      ab_op = op; pc_inc = inc; ld_lo = ld; wr = w; vec = v; SB = sbv; DB = dbv; RDY = rdy;
      sb_q.push_back({eab, epc, efix});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_now(tag, e);
   endtask

   initial begin
      // Asynchronous reset asserted mid-cycle
      #3 RST = 1'b1;
      #1 check_now("rst_async", {16'hFFFC, 16'h0000, 1'b0});
      @(posedge clk); #1 RST = 1'b0;

      step("vec_nmi", AB_VEC, 0, 0, 0, 2'b01, 8'h00, 8'h00, 1, 16'hFFFA, 16'h0000, 0);
      step("ld_ff",   AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'hFF, 1, 16'hFFFA, 16'h0000, 0);
      step("jmp12ff", AB_JMP, 0, 0, 0, 2'b00, 8'h00, 8'h12, 1, 16'h12FF, 16'h12FF, 0);
      step("fetch1",  AB_PC,  1, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h12FF, 16'h1300, 0);
      step("fetch2",  AB_PC,  1, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h1300, 16'h1301, 0);

      // Absolute index without page crossing
      step("ld_20",   AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'h20, 1, 16'h1300, 16'h1301, 0);
      step("abs_nc",  AB_ABS, 0, 0, 0, 2'b00, 8'h10, 8'h30, 1, 16'h3030, 16'h1301, 0);
      step("abs_nc2", AB_HOLD,0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h3030, 16'h1301, 0);

      // Page cross; commands presented during FIX are ignored
      step("ld_f0",   AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'hF0, 1, 16'h3030, 16'h1301, 0);
      step("abs_x",   AB_ABS, 0, 0, 0, 2'b00, 8'h20, 8'h30, 1, 16'h3010, 16'h1301, 1);
      step("fix_x",   AB_PC,  1, 1, 0, 2'b00, 8'h00, 8'h55, 1, 16'h3110, 16'h1301, 0);
      step("zp_wrap", AB_ZP,  0, 0, 0, 2'b00, 8'h20, 8'hF0, 1, 16'h0010, 16'h1301, 0);
      step("lo_kept", AB_ABS, 0, 0, 0, 2'b00, 8'h00, 8'h77, 1, 16'h77F0, 16'h1301, 0);

      // Write forces fix cycle with unchanged address
      step("ld_05",   AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'h05, 1, 16'h77F0, 16'h1301, 0);
      step("abs_wr",  AB_ABS, 0, 0, 1, 2'b00, 8'h01, 8'h40, 1, 16'h4006, 16'h1301, 1);
      step("fix_wr",  AB_HOLD,0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h4006, 16'h1301, 0);

      // Fix on page FF wraps to page 00; RDY low holds FIX
      step("ld_ff2",  AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'hFF, 1, 16'h4006, 16'h1301, 0);
      step("abs_ff",  AB_ABS, 0, 0, 0, 2'b00, 8'h02, 8'hFF, 1, 16'hFF01, 16'h1301, 1);
      for (int i = 0; i < 3; i++)
         step("rdy_lo", AB_PC, 1, 1, 0, 2'b00, 8'h00, 8'h00, 0, 16'hFF01, 16'h1301, 1);
      step("fix_ff",  AB_HOLD,0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h0001, 16'h1301, 0);

      // ABS with simultaneous ld_lo uses the old LO
      step("abs_old", AB_ABS, 0, 1, 0, 2'b00, 8'h00, 8'h10, 1, 16'h10FF, 16'h1301, 0);
      step("jmp_new", AB_JMP, 0, 0, 0, 2'b00, 8'h00, 8'h20, 1, 16'h2010, 16'h2010, 0);

      step("stk",     AB_STK, 0, 0, 0, 2'b00, 8'hFD, 8'h00, 1, 16'h01FD, 16'h2010, 0);
      step("nxt",     AB_NXT, 0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h01FE, 16'h2010, 0);
      step("stk_ff",  AB_STK, 0, 0, 0, 2'b00, 8'hFF, 8'h00, 1, 16'h01FF, 16'h2010, 0);
      step("nxt_wr",  AB_NXT, 0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h0100, 16'h2010, 0);
      step("vec_00",  AB_VEC, 0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'hFFFE, 16'h2010, 0);
      step("vec_10",  AB_VEC, 0, 0, 0, 2'b10, 8'h00, 8'h00, 1, 16'hFFFC, 16'h2010, 0);
      step("vec_11",  AB_VEC, 0, 0, 0, 2'b11, 8'h00, 8'h00, 1, 16'hFFFE, 16'h2010, 0);

      // Jump with increment, PC wrap
      step("ld_34",   AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'h34, 1, 16'hFFFE, 16'h2010, 0);
      step("jmp1234", AB_JMP, 1, 0, 0, 2'b00, 8'h00, 8'h12, 1, 16'h1234, 16'h1235, 0);
      step("ld_ff3",  AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'hFF, 1, 16'h1234, 16'h1235, 0);
      step("jmpffff", AB_JMP, 0, 0, 0, 2'b00, 8'h00, 8'hFF, 1, 16'hFFFF, 16'hFFFF, 0);
      step("pc_wrap", AB_PC,  1, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'hFFFF, 16'h0000, 0);

      // Reset during FIX aborts the fixup
      step("ld_f0b",  AB_HOLD,0, 1, 0, 2'b00, 8'h00, 8'hF0, 1, 16'hFFFF, 16'h0000, 0);
      step("abs_x2",  AB_ABS, 0, 0, 0, 2'b00, 8'h20, 8'h30, 1, 16'h3010, 16'h0000, 1);
      #2 RST = 1'b1;
      #1 check_now("rst_fix", {16'hFFFC, 16'h0000, 1'b0});
      @(posedge clk); #1 RST = 1'b0;
      step("post_rst",AB_PC,  0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 16'h0000, 16'h0000, 0);
      step("post_lo", AB_JMP, 0, 0, 0, 2'b00, 8'h00, 8'hAB, 1, 16'hAB00, 16'hAB00, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
